// File: rtl/block_io_sequencer_pkg.sv
// Shared definitions for the block I/O sequencer: state encoding, T-state
// numbering and the phase-to-strobe mapping used by the top level.
package block_io_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PH1,
      ST_PH2,
      ST_UPD,
      ST_REP
   } state_t;

   localparam int T_FIRST   = 5;
   localparam int T_IO_LEN  = 4;
   localparam int T_MEM_LEN = 3;
   localparam int T_UPD     = T_FIRST + T_IO_LEN + T_MEM_LEN;

   typedef struct packed {
      logic io_rd;
      logic io_wr;
      logic mem_rd;
      logic mem_wr;
      logic addr_sel;
   } strobes_t;

   // Input form runs IO then MEM, output form runs MEM then IO.
   function automatic strobes_t phase_strobes(input state_t st, input logic op_out);
      strobes_t s;
      s = '0;
      if ((st == ST_PH1 && !op_out) || (st == ST_PH2 && op_out)) begin
         s.io_rd = !op_out;
         s.io_wr = op_out;
      end else if ((st == ST_PH1 && op_out) || (st == ST_PH2 && !op_out)) begin
         s.mem_rd   = op_out;
         s.mem_wr   = !op_out;
         s.addr_sel = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/block_io_sequencer_tcounter.sv
// T-state counter: clears to 0, loads T5 at each PH1, holds during waits and
// flags the wait-sample and phase-end T-states for the current transfer form.
module block_io_sequencer_tcounter
   import block_io_sequencer_pkg::*;
#(
   parameter int T_REP = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       hold,
   input  logic       advance,
   input  logic       op_out,
   output logic [4:0] tstate,
   output logic       ph1_wait,
   output logic       ph2_wait,
   output logic       ph1_end,
   output logic       ph2_end,
   output logic       rep_end
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tstate <= '0;
      end else if (load) begin
         tstate <= 5'(T_FIRST);
      end else if (advance && !hold) begin
         tstate <= tstate + 5'd1;
      end
   end

   // PH2 wait point is T10 in both forms: 2nd MEM cycle (input), 3rd IO cycle (output).
   assign ph1_wait = tstate == (op_out ? 5'(T_FIRST + 1) : 5'(T_FIRST + 2));
   assign ph2_wait = tstate == 5'(T_UPD - 2);
   assign ph1_end  = tstate == (op_out ? 5'(T_FIRST + T_MEM_LEN - 1) : 5'(T_FIRST + T_IO_LEN - 1));
   assign ph2_end  = tstate == 5'(T_UPD - 1);
   assign rep_end  = tstate == 5'(T_UPD + T_REP);

endmodule

// File: rtl/block_io_sequencer.sv
// Self-timed sequencer for the Z80-style block I/O instructions; iterates on B
// internally and can leave early on a pending interrupt with a PC-rewind request.
module block_io_sequencer
   import block_io_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8,
   parameter int T_REP  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op_out,
   input  logic              op_dec,
   input  logic              op_rep,
   input  logic [CNT_W-1:0]  b_in,
   input  logic [DATA_W-1:0] io_din,
   input  logic [DATA_W-1:0] mem_din,
   input  logic              io_wait,
   input  logic              mem_wait,
   input  logic              irq_pending,
   output logic              busy,
   output logic              done,
   output logic              pc_rewind,
   output logic [4:0]        tstate,
   output logic              io_rd,
   output logic              io_wr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              addr_sel,
   output logic [DATA_W-1:0] data_q,
   output logic [CNT_W-1:0]  b_cnt,
   output logic              b_dec,
   output logic              hl_inc,
   output logic              hl_dec,
   output logic              flag_we,
   output logic              flag_z,
   output logic              flag_n
);

   state_t           state;
   strobes_t         strb;
   logic             op_out_q, op_dec_q, op_rep_q, done_r;
   logic             cnt_load, cnt_clear, cnt_hold, cnt_adv, irq_exit;
   logic             ph1_wait, ph2_wait, ph1_end, ph2_end, rep_end;
   logic [CNT_W-1:0] b_next;

   assign b_next = b_cnt - CNT_W'(1);

   block_io_sequencer_tcounter #(.T_REP(T_REP)) u_tcounter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .hold     (cnt_hold),
      .advance  (cnt_adv),
      .op_out   (op_out_q),
      .tstate   (tstate),
      .ph1_wait (ph1_wait),
      .ph2_wait (ph2_wait),
      .ph1_end  (ph1_end),
      .ph2_end  (ph2_end),
      .rep_end  (rep_end)
   );

   // The interrupt exit must complete in the same last REP cycle it is sampled.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_clear = 1'b0;
      cnt_hold  = 1'b0;
      irq_exit  = 1'b0;
      cnt_adv   = (state != ST_IDLE);
      case (state)
         ST_IDLE: cnt_load = start;
         ST_PH1:  cnt_hold = ph1_wait && (op_out_q ? mem_wait : io_wait);
         ST_PH2:  cnt_hold = ph2_wait && (op_out_q ? io_wait : mem_wait);
         ST_UPD:  cnt_clear = done_r;
         ST_REP: begin
            if (rep_end) begin
               if (irq_pending) begin
                  cnt_clear = 1'b1;
                  irq_exit  = !reset;
               end else begin
                  cnt_load = 1'b1;
               end
            end
         end
         default: cnt_clear = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         strb     <= '0;
         busy     <= 1'b0;
         done_r   <= 1'b0;
         op_out_q <= 1'b0;
         op_dec_q <= 1'b0;
         op_rep_q <= 1'b0;
         data_q   <= '0;
         b_cnt    <= '0;
         b_dec    <= 1'b0;
         hl_inc   <= 1'b0;
         hl_dec   <= 1'b0;
         flag_we  <= 1'b0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         b_dec   <= 1'b0;
         hl_inc  <= 1'b0;
         hl_dec  <= 1'b0;
         flag_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_PH1;
                  busy     <= 1'b1;
                  op_out_q <= op_out;
                  op_dec_q <= op_dec;
                  op_rep_q <= op_rep;
                  b_cnt    <= b_in;
                  strb     <= phase_strobes(ST_PH1, op_out);
               end
            end
            ST_PH1: begin
               // The last PH1 cycle is the last IO cycle (input) or last MEM cycle (output).
               if (ph1_end) begin
                  state  <= ST_PH2;
                  strb   <= phase_strobes(ST_PH2, op_out_q);
                  data_q <= op_out_q ? mem_din : io_din;
               end
            end
            ST_PH2: begin
               if (ph2_end) begin
                  state   <= ST_UPD;
                  strb    <= '0;
                  b_cnt   <= b_next;
                  b_dec   <= 1'b1;
                  hl_inc  <= !op_dec_q;
                  hl_dec  <= op_dec_q;
                  flag_we <= 1'b1;
                  flag_z  <= (b_next == '0);
                  flag_n  <= data_q[DATA_W-1];
                  done_r  <= !op_rep_q || (b_next == '0);
               end
            end
            ST_UPD: begin
               if (done_r) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_REP;
               end
            end
            ST_REP: begin
               if (rep_end) begin
                  if (irq_pending) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_PH1;
                     strb  <= phase_strobes(ST_PH1, op_out_q);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               strb  <= '0;
            end
         endcase
      end
   end

   assign done      = done_r | irq_exit;
   assign pc_rewind = irq_exit;
   assign io_rd     = strb.io_rd;
   assign io_wr     = strb.io_wr;
   assign mem_rd    = strb.mem_rd;
   assign mem_wr    = strb.mem_wr;
   assign addr_sel  = strb.addr_sel;

endmodule

// File: tb/tb_block_io_sequencer.sv
// Scoreboard bench for block_io_sequencer: directed block transfers push their
// expected completion into a queue that a monitor pops on every done pulse.
module tb_block_io_sequencer;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;
   localparam int T_REP  = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              op_out = 1'b0;
   logic              op_dec = 1'b0;
   logic              op_rep = 1'b0;
   logic [CNT_W-1:0]  b_in = '0;
   logic [DATA_W-1:0] io_din = '0;
   logic [DATA_W-1:0] mem_din = '0;
   logic              io_wait = 1'b0;
   logic              mem_wait = 1'b0;
   logic              irq_pending = 1'b0;
   logic              busy, done, pc_rewind;
   logic [4:0]        tstate;
   logic              io_rd, io_wr, mem_rd, mem_wr, addr_sel;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  b_cnt;
   logic              b_dec, hl_inc, hl_dec, flag_we, flag_z, flag_n;

   typedef struct {
      int               done_cyc;
      logic [CNT_W-1:0] b;
      logic             z;
      logic             n;
      logic             rew;
      logic [DATA_W-1:0] dq;
      int               upd;
      int               inc;
      int               dec;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   upd_seen = 0;
   int   inc_seen = 0;
   int   dec_seen = 0;

   block_io_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .T_REP(T_REP)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op_out      (op_out),
      .op_dec      (op_dec),
      .op_rep      (op_rep),
      .b_in        (b_in),
      .io_din      (io_din),
      .mem_din     (mem_din),
      .io_wait     (io_wait),
      .mem_wait    (mem_wait),
      .irq_pending (irq_pending),
      .busy        (busy),
      .done        (done),
      .pc_rewind   (pc_rewind),
      .tstate      (tstate),
      .io_rd       (io_rd),
      .io_wr       (io_wr),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .addr_sel    (addr_sel),
      .data_q      (data_q),
      .b_cnt       (b_cnt),
      .b_dec       (b_dec),
      .hl_inc      (hl_inc),
      .hl_dec      (hl_dec),
      .flag_we     (flag_we),
      .flag_z      (flag_z),
      .flag_n      (flag_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic pushExp(input int dc, input logic [CNT_W-1:0] b, input logic z, input logic n,
                          input logic rew, input logic [DATA_W-1:0] dq,
                          input int upd, input int inc, input int dec);
      exp_t e;
      e.done_cyc = dc;
      e.b = b;
      e.z = z;
      e.n = n;
      e.rew = rew;
      e.dq = dq;
      e.upd = upd;
      e.inc = inc;
      e.dec = dec;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the next negedge with k = the start cycle.
   task automatic applyStimulus(input logic o, input logic d, input logic r, input logic [CNT_W-1:0] b,
                                input logic [DATA_W-1:0] iod, input logic [DATA_W-1:0] memd,
                                output int k);
      op_out  = o;
      op_dec  = d;
      op_rep  = r;
      b_in    = b;
      io_din  = iod;
      mem_din = memd;
      start   = 1'b1;
      k       = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput({name, "_timeout"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: strobe legality every cycle, scoreboard pop on every done.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            upd_seen = 0;
            inc_seen = 0;
            dec_seen = 0;
         end else begin
            checkOutput("strobe_exclusive",
                        32'(($countones({io_rd, io_wr, mem_rd, mem_wr}) <= 1) &&
                            (busy || !(io_rd | io_wr | mem_rd | mem_wr))), 32'd1);
            if (b_dec) upd_seen++;
            if (hl_inc) inc_seen++;
            if (hl_dec) dec_seen++;
            if (done) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("done_cycle", cyc, e.done_cyc);
                  checkOutput("b_cnt", 32'(b_cnt), 32'(e.b));
                  checkOutput("flag_z", 32'(flag_z), 32'(e.z));
                  checkOutput("flag_n", 32'(flag_n), 32'(e.n));
                  checkOutput("pc_rewind", 32'(pc_rewind), 32'(e.rew));
                  checkOutput("data_q", 32'(data_q), 32'(e.dq));
                  checkOutput("upd_pulses", upd_seen, e.upd);
                  checkOutput("hl_inc_pulses", inc_seen, e.inc);
                  checkOutput("hl_dec_pulses", dec_seen, e.dec);
               end
               upd_seen = 0;
               inc_seen = 0;
               dec_seen = 0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_ctrl", 32'({busy, done, pc_rewind, tstate, io_rd, io_wr, mem_rd, mem_wr,
                                     addr_sel, b_dec, hl_inc, hl_dec, flag_we, flag_z, flag_n}), 32'd0);
      checkOutput("reset_data", 32'({data_q, b_cnt}), 32'd0);

      $display("[TB] INI b=3");
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 8'hA5, 8'h3C, k);
      pushExp(k + 8, 8'd2, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         checkOutput($sformatf("ini_strobes_c%0d", i), 32'({addr_sel, io_rd, io_wr, mem_rd, mem_wr}),
                     (i <= 4) ? 32'b01000 : (i <= 7) ? 32'b10001 : 32'b0);
         checkOutput($sformatf("ini_tstate_c%0d", i), 32'(tstate), 32'(4 + i));
      end
      waitIdle("ini", 20);

      $display("[TB] OTIR b=2 with a start pulse while busy");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'h00, 8'h42, k);
      pushExp(k + 16 + T_REP, 8'd0, 1'b1, 1'b0, 1'b0, 8'h42, 2, 2, 0);
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 4) begin
            start = 1'b1;
            b_in  = 8'd7;
         end
         if (i == 5) start = 1'b0;
         checkOutput($sformatf("otir_strobes_c%0d", i), 32'({addr_sel, io_rd, io_wr, mem_rd, mem_wr}),
                     (i <= 3) ? 32'b10010 : (i <= 7) ? 32'b00100 : 32'b0);
      end
      waitIdle("otir", 100);

      $display("[TB] INIR b=0 (256 iterations)");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 8'h80, 8'h00, k);
      pushExp(k + 8 + 255 * (8 + T_REP), 8'd0, 1'b1, 1'b1, 1'b0, 8'h80, 256, 256, 0);
      waitIdle("inir", 4000);

      $display("[TB] INDR b=5 with interrupt from iteration 2");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd5, 8'h11, 8'h00, k);
      pushExp(k + 2 * (8 + T_REP), 8'd3, 1'b0, 1'b0, 1'b1, 8'h11, 2, 0, 2);
      repeat (8 + T_REP) @(negedge clk);
      irq_pending = 1'b1;
      waitIdle("indr", 100);
      irq_pending = 1'b0;

      $display("[TB] INI b=1 with io_wait for 3 cycles");
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 8'h5A, 8'h00, k);
      pushExp(k + 11, 8'd0, 1'b1, 1'b0, 1'b0, 8'h5A, 1, 1, 0);
      for (int i = 2; i <= 7; i++) begin
         @(negedge clk);
         checkOutput($sformatf("wait_tstate_c%0d", i), 32'(tstate), (i == 2) ? 32'd6 : (i == 7) ? 32'd8 : 32'd7);
         if (i == 3) io_wait = 1'b1;
         if (i == 6) io_wait = 1'b0;
      end
      waitIdle("iowait", 30);

      $display("[TB] reset during MEM phase of INI");
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd4, 8'hFF, 8'h00, k);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_ctrl", 32'({busy, done, pc_rewind, tstate, io_rd, io_wr, mem_rd, mem_wr,
                                     addr_sel, b_dec, hl_inc, hl_dec, flag_we, flag_z, flag_n}), 32'd0);
      checkOutput("abort_data", 32'({data_q, b_cnt}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 8'h01, 8'h00, k);
      pushExp(k + 8, 8'd0, 1'b1, 1'b0, 1'b0, 8'h01, 1, 1, 0);
      waitIdle("restart", 20);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
